// File: rtl/opb_status_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : opb_status_bank_pkg
//  Description : Shared definitions for the OPB status bank: register offsets
//                derived from the channel count, CTRL bit positions and the
//                bus-handshake state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package opb_status_bank_pkg;

    // CTRL word bit positions (LSB numbering, i.e. OPB DBus[31] is bit 0)
    localparam int CTRL_FREEZE_BIT = 0;
    localparam int CTRL_SNAP_BIT   = 1;

    // Bus handshake states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACK  = 1'b1
    } opb_state_e;

    // CTRL sits directly after the last channel word
    function automatic logic [31:0] ctrl_ofs(input int num_ch);
        return 32'(num_ch);
    endfunction

    // CAPCNT follows CTRL
    function automatic logic [31:0] capcnt_ofs(input int num_ch);
        return 32'(num_ch + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/opb_status_chan.sv
`default_nettype none
// ============================================================================
//  Module      : opb_status_chan
//  Description : One status channel register. Loads din_i on load_i; in the
//                sticky build (OPB_STATUS_BANK_STICKY_EN) it accumulates
//                instead and supports write-1-to-clear, with a same-cycle
//                set taking priority over the clear.
//  Revision    : 1.0 - initial release
//
//  Ports       : clk_i   - clock
//                rst_ni  - asynchronous active-low reset
//                load_i  - capture strobe
//                din_i   - channel input data
//                clr_i   - clear mask (sticky build only)
//                q_o     - current register value
// ============================================================================
module opb_status_chan
    import opb_status_bank_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [DWIDTH-1:0] din_i,
    input  logic [DWIDTH-1:0] clr_i,
    output logic [DWIDTH-1:0] q_o
);

    logic [DWIDTH-1:0] data_q;
    logic [DWIDTH-1:0] data_d;

`ifdef OPB_STATUS_BANK_STICKY_EN
    // Clear first, then OR in new data so a coincident set survives
    always_comb begin
        data_d = data_q & ~clr_i;
        if (load_i) begin
            data_d = data_d | din_i;
        end
    end
`else
    logic unused_clr;
    assign unused_clr = ^clr_i;

    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = din_i;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule
`default_nettype wire

// File: rtl/opb_status_bank.sv
`default_nettype none
// ============================================================================
//  Module      : opb_status_bank
//  Description : Bank of C_NUM_CH read-only status words on the OPB bus, plus
//                a CTRL word (freeze, snapshot request) and a 32-bit capture
//                counter. Capture is continuous (C_CAPTURE_MODE=0, per-channel
//                user_valid) or on-demand (C_CAPTURE_MODE=1, snap write).
//                Build option: OPB_STATUS_BANK_STICKY_EN makes channels
//                accumulate and adds write-1-to-clear on channel offsets.
//  Revision    : 1.0 - initial release
//
//  Ports       : OPB_Clk/OPB_Rst_n      - clock, async active-low reset
//                OPB_ABus/BE/DBus/RNW   - OPB slave request
//                OPB_select/seqAddr     - transaction valid / ignored
//                Sl_DBus/Sl_xferAck     - read data (zero when idle) / ack
//                Sl_errAck/retry/toutSup- tied low
//                user_data_in           - channel i at [i*C_DWIDTH +: C_DWIDTH]
//                user_valid             - per-channel data strobe
// ============================================================================
module opb_status_bank
    import opb_status_bank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR     = 32'h01087100,
    parameter logic [31:0] C_HIGHADDR     = 32'h010871FF,
    parameter int          C_NUM_CH       = 4,
    parameter int          C_DWIDTH       = 32,
    parameter int          C_CAPTURE_MODE = 0
) (
    input  logic                         OPB_Clk,
    input  logic                         OPB_Rst_n,
    input  logic [31:0]                  OPB_ABus,
    input  logic [3:0]                   OPB_BE,
    input  logic [31:0]                  OPB_DBus,
    input  logic                         OPB_RNW,
    input  logic                         OPB_select,
    input  logic                         OPB_seqAddr,
    output logic [31:0]                  Sl_DBus,
    output logic                         Sl_xferAck,
    output logic                         Sl_errAck,
    output logic                         Sl_retry,
    output logic                         Sl_toutSup,
    input  logic [C_NUM_CH*C_DWIDTH-1:0] user_data_in,
    input  logic [C_NUM_CH-1:0]          user_valid
);

    localparam logic [31:0] CTRL_OFS   = ctrl_ofs(C_NUM_CH);
    localparam logic [31:0] CAPCNT_OFS = capcnt_ofs(C_NUM_CH);

    opb_state_e        state_q;
    logic              xfer_ack_q;
    logic [31:0]       sl_dbus_q;

    logic              freeze_q;
    logic              freeze_d;
    logic              snap_pend_q;
    logic              snap_pend_d;
    logic [31:0]       capcnt_q;
    logic [31:0]       capcnt_d;

    logic              hit;
    logic              wr_en;
    logic              ctrl_wr;
    logic              capture;
    logic [31:0]       word_ofs;
    logic [31:0]       rdata;
    logic [C_NUM_CH-1:0] load;
    logic [C_DWIDTH-1:0] ch_val [C_NUM_CH];

    logic              unused_inputs;
    assign unused_inputs = ^{OPB_seqAddr, OPB_BE[2:0], OPB_DBus, user_valid, snap_pend_q};

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    assign hit      = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
    assign word_ofs = (OPB_ABus - C_BASEADDR) >> 2;
    // Writes happen only on the first (IDLE) cycle of a transaction
    assign wr_en    = hit && (state_q == IDLE) && !OPB_RNW;
    // BE[3] owns DBus[24:31] in OPB numbering, i.e. the LSB byte here
    assign ctrl_wr  = wr_en && (word_ofs == CTRL_OFS) && OPB_BE[3];

    // Read mux uses current register values, so a same-cycle load is not seen
    always_comb begin
        rdata = '0;
        for (int i = 0; i < C_NUM_CH; i++) begin
            if (word_ofs == 32'(i)) begin
                rdata = 32'(ch_val[i]);
            end
        end
        if (word_ofs == CTRL_OFS) begin
            rdata[CTRL_FREEZE_BIT] = freeze_q;
        end
        if (word_ofs == CAPCNT_OFS) begin
            rdata = capcnt_q;
        end
    end

    // ------------------------------------------------------------------
    // CTRL / snapshot / counter
    // ------------------------------------------------------------------
    // A snap is armed only if neither the current nor the written freeze is set
    always_comb begin
        freeze_d    = freeze_q;
        snap_pend_d = 1'b0;
        if (ctrl_wr) begin
            freeze_d    = OPB_DBus[CTRL_FREEZE_BIT];
            snap_pend_d = OPB_DBus[CTRL_SNAP_BIT] && !OPB_DBus[CTRL_FREEZE_BIT] && !freeze_q;
        end
    end

    generate
        if (C_CAPTURE_MODE == 0) begin : g_mode_cont
            assign load    = freeze_q ? '0 : user_valid;
            assign capture = !freeze_q && (|user_valid);
        end else begin : g_mode_snap
            assign load    = {C_NUM_CH{snap_pend_q && !freeze_q}};
            assign capture = snap_pend_q && !freeze_q;
        end
    endgenerate

    always_comb begin
        capcnt_d = capcnt_q;
        if (capture) begin
            capcnt_d = capcnt_q + 32'd1;
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            freeze_q    <= 1'b0;
            snap_pend_q <= 1'b0;
            capcnt_q    <= '0;
        end else begin
            freeze_q    <= freeze_d;
            snap_pend_q <= snap_pend_d;
            capcnt_q    <= capcnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Channels
    // ------------------------------------------------------------------
`ifdef OPB_STATUS_BANK_STICKY_EN
    logic [31:0] be_mask;
    assign be_mask = {{8{OPB_BE[0]}}, {8{OPB_BE[1]}}, {8{OPB_BE[2]}}, {8{OPB_BE[3]}}};
`endif

    for (genvar i = 0; i < C_NUM_CH; i++) begin : g_chan
        logic [C_DWIDTH-1:0] clr;
`ifdef OPB_STATUS_BANK_STICKY_EN
        assign clr = (wr_en && (word_ofs == 32'(i))) ?
                     (OPB_DBus[C_DWIDTH-1:0] & be_mask[C_DWIDTH-1:0]) : '0;
`else
        assign clr = '0;
`endif
        opb_status_chan #(
            .DWIDTH (C_DWIDTH)
        ) u_chan (
            .clk_i  (OPB_Clk),
            .rst_ni (OPB_Rst_n),
            .load_i (load[i]),
            .din_i  (user_data_in[i*C_DWIDTH +: C_DWIDTH]),
            .clr_i  (clr),
            .q_o    (ch_val[i])
        );
    end

    // ------------------------------------------------------------------
    // Bus handshake: one ack cycle per transaction; select still present
    // during ACK belongs to the same transaction.
    // ------------------------------------------------------------------
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state_q    <= IDLE;
            xfer_ack_q <= 1'b0;
            sl_dbus_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hit) begin
                        state_q    <= ACK;
                        xfer_ack_q <= 1'b1;
                        sl_dbus_q  <= OPB_RNW ? rdata : '0;
                    end else begin
                        xfer_ack_q <= 1'b0;
                        sl_dbus_q  <= '0;
                    end
                end
                ACK: begin
                    state_q    <= IDLE;
                    xfer_ack_q <= 1'b0;
                    sl_dbus_q  <= '0;
                end
                default: begin
                    state_q    <= IDLE;
                    xfer_ack_q <= 1'b0;
                    sl_dbus_q  <= '0;
                end
            endcase
        end
    end

    assign Sl_xferAck = xfer_ack_q;
    assign Sl_DBus    = sl_dbus_q;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

endmodule
`default_nettype wire

// File: doc/opb_status_bank.md
Name: opb_status_bank

Overview:
- Parametrised successor to the single-word simulink-to-PPC status register.
- Presents C_NUM_CH status channels, each C_DWIDTH bits wide, as read-only words on the OPB bus.
- Adds a control word (freeze, snapshot request), a capture counter and a selectable capture mode.
- Sits beside the snapshot/ADC-calibration blocks. Status sources are already synchronous to OPB_Clk, so there is no clock crossing.

Parameters:
- C_BASEADDR, 32'h01087100, first byte address of the bank.
- C_HIGHADDR, 32'h010871FF, last byte address; must cover 4*(C_NUM_CH+2) bytes.
- C_NUM_CH, 4, number of status channels (1..32).
- C_DWIDTH, 32, channel width (1..32); reads are zero-extended to 32 bits.
- C_CAPTURE_MODE, 0, capture mode:
  - 0 = continuous: a channel updates on every user_valid.
  - 1 = on-demand: channels update only on a snapshot request.

Ports:
- OPB_Clk  in  1  sole clock.
- OPB_Rst_n  in  1  asynchronous active-low reset.
- OPB_ABus  in  32  address.
- OPB_BE  in  4  byte enables; BE[3] = DBus[24:31].
- OPB_DBus  in  32  write data.
- OPB_RNW  in  1  1 = read.
- OPB_select  in  1  transaction valid.
- OPB_seqAddr  in  1  ignored.
- Sl_DBus  out  32  read data; zero when not acking.
- Sl_xferAck  out  1  transfer acknowledge.
- Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied 0.
- user_data_in  in  C_NUM_CH*C_DWIDTH  channel i occupies bits [i*C_DWIDTH +: C_DWIDTH].
- user_valid  in  C_NUM_CH  per-channel data-valid strobe.

Behaviour:
- Reset: all outputs 0, channel registers 0, control 0, count 0, FSM in IDLE.
- Address map (word offsets from C_BASEADDR):
  - 0..N-1: channel registers, read-only.
  - N: CTRL. Bit0 = freeze (RW). Bit1 = snap (write-1, self-clearing, reads 0).
  - N+1: CAPCNT, 32-bit read-only, wraps 0xFFFFFFFF -> 0.
  - Reads of unused offsets inside the range return 0.
- Address decode: hit = OPB_select & (C_BASEADDR <= ABus <= C_HIGHADDR).
- OPB FSM:
  - IDLE: on hit, register read data and perform the write; go to ACK.
  - ACK: Sl_xferAck=1 and Sl_DBus=data for exactly one cycle; return to IDLE unconditionally.
  - A hit still present in the ACK cycle is not a new transaction. Latency is 1 cycle from select to ack.
- Writes:
  - CTRL is updated only when BE[3]=1. Other lanes are ignored.
  - Writes to read-only offsets are acked and discarded.
- Capture, mode 0: while freeze=0, channel i loads its slice on user_valid[i]. CAPCNT increments once per cycle in which any valid is high.
- Capture, mode 1: a snap write (while freeze=0) loads all channels from user_data_in in the cycle after the write cycle, regardless of user_valid. CAPCNT increments by 1.
- freeze=1 blocks all channel loads and CAPCNT. A snap written while frozen is discarded. A single write with freeze=1 and snap=1 is discarded.
- A read in the same cycle as a channel load returns the pre-load value.

Optional Feature:
- Macro: OPB_STATUS_BANK_STICKY_EN.
- When defined:
  - Channel registers accumulate (reg |= new) instead of loading.
  - Writing a channel offset clears the bits written as 1 (W1C, honouring all four byte lanes).
  - A set and a clear of the same bit in the same cycle: the set wins.
- When undefined: channels are load-only, and channel writes are discarded as above.

Decomposition:
- Package opb_status_bank_pkg:
  - Offset constants CTRL_OFS and CAPCNT_OFS as functions of C_NUM_CH.
  - CTRL bit indices.
  - FSM state enum {IDLE, ACK}.
- One sub-module, opb_status_chan: a single channel register with load/sticky/clear logic, instantiated C_NUM_CH times via generate.

Test Plan:
1. Reset, then read offset 0 -> Sl_xferAck high exactly 1 cycle after select, Sl_DBus=0. Errack/retry/toutsup stay 0.
2. Mode 0, N=4, W=16: drive channel 2 = 0xBEEF with valid[2] pulse; read base+0x08 -> 0x0000BEEF. Read CAPCNT -> 1.
3. Write CTRL=0x1 (freeze); pulse valid[2] with 0x1234; read -> still 0xBEEF, CAPCNT still 1. Write CTRL=0x0; pulse again -> 0x1234.
4. Mode 1: data present with valid=0; write CTRL=0x2 -> all channels hold the inputs from the cycle after the write. CTRL reads 0x0, CAPCNT=1. Write CTRL=0x3 -> no capture.
5. Sticky build: feed 0x0F then 0xF0 -> read 0xFF. Write 0x0F to the channel -> 0xF0. Clear bit 4 while input sets bit 4 -> bit 4 remains 1.
6. Preload CAPCNT to 0xFFFFFFFF via force, then one valid -> reads 0. Assert OPB_Rst_n low mid-ack -> Sl_xferAck drops immediately (asynchronous), all registers 0.
